// File: rtl/imem_block_responder_if.sv
// imem_block_responder_if
//   Block-read and preload bus between the instruction memory responder and
//   its initiators.
//   master : drives READ/ADDRESS (block read) and LOAD_EN/LOAD_ADDR/LOAD_DATA
//            (byte preload); observes READDATA, BUSYWAIT and LOAD_ERR.
//   slave  : the responder side, the mirror image of master.
interface imem_block_responder_if #(
    parameter int BLOCK_AW = 6
);
    logic                  READ;
    logic [BLOCK_AW-1:0]   ADDRESS;
    logic [127:0]          READDATA;
    logic                  BUSYWAIT;
    logic                  LOAD_EN;
    logic [BLOCK_AW+3:0]   LOAD_ADDR;
    logic [7:0]            LOAD_DATA;
    logic                  LOAD_ERR;

    modport master (
        output READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        input  READDATA, BUSYWAIT, LOAD_ERR
    );

    modport slave (
        input  READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        output READDATA, BUSYWAIT, LOAD_ERR
    );
endinterface

// File: rtl/imem_block_responder.sv
// imem_block_responder
//   Read-only instruction memory answering 16-byte block reads from an
//   instruction cache after a fixed latency, with a BUSYWAIT handshake.
//   A byte-wide preload port fills the array while the responder is idle.
// Ports
//   CLK    : clock, rising edge active
//   RESET  : asynchronous, active-low reset (memory contents are kept)
//   bus    : slave side of imem_block_responder_if
//            READ/ADDRESS -> READDATA after LATENCY edges, BUSYWAIT while busy
//            LOAD_EN/LOAD_ADDR/LOAD_DATA -> byte write, LOAD_ERR when refused
module imem_block_responder #(
    parameter int BLOCK_AW = 6,
    parameter int LATENCY  = 5
) (
    input  logic                   CLK,
    input  logic                   RESET,
    imem_block_responder_if.slave  bus
);
    localparam int                 CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LATENCY - 1);
    localparam int                 MEM_SZ   = 2 ** (BLOCK_AW + 4);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BLOCK_AW-1:0]   addr_q;
    logic [7:0]            mem [0:MEM_SZ-1];
    logic [127:0]          block_rd;
    logic                  load_ok;

    // Busy is visible in the same cycle the request appears, so the
    // initiator never sees a gap before the transaction is accepted.
    assign bus.BUSYWAIT = (state == IDLE && bus.READ) || state == BUSY;

    // A pending or in-flight read always wins over a preload write.
    assign load_ok = (state == IDLE) && !bus.READ;

    // Little-endian block: byte k of the block sits in READDATA[8k+7:8k].
    always_comb begin
        block_rd = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            block_rd[8*k +: 8] = mem[{addr_q, k[3:0]}];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            bus.READDATA <= '0;
            bus.LOAD_ERR <= 1'b0;
        end else begin
            bus.LOAD_ERR <= bus.LOAD_EN && !load_ok;
            case (state)
                IDLE: begin
                    if (bus.READ) begin
                        addr_q <= bus.ADDRESS;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_LAST) begin
                        bus.READDATA <= block_rd;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array is deliberately left out of reset so a preloaded program
    // survives a reset pulse.
    always_ff @(posedge CLK) begin
        if (bus.LOAD_EN && load_ok) begin
            mem[bus.LOAD_ADDR] <= bus.LOAD_DATA;
        end
    end
endmodule

// File: tb/tb_imem_block_responder.sv
// tb_imem_block_responder
//   Randomised and directed stimulus for imem_block_responder. A transaction
//   level reference (byte array plus "read completes LATENCY edges after
//   acceptance") produces expected blocks into a scoreboard queue; a monitor
//   pops and compares whenever the DUT ends a busy period.
module tb_imem_block_responder;
    localparam int BLOCK_AW = 6;
    localparam int LAT      = 5;
    localparam logic [127:0] PAT1 = 128'h0F0E0D0C0B0A09080706050403020100;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    imem_block_responder_if #(.BLOCK_AW(BLOCK_AW)) bus ();

    imem_block_responder #(.BLOCK_AW(BLOCK_AW), .LATENCY(LAT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [7:0]   model_mem [1024];
    logic [127:0] exp_q [$];
    logic [127:0] exp_rd  = '0;
    logic         exp_err = 1'b0;
    logic         prev_bw = 1'b0;
    int           cyc     = 0;
    int           done_at = -10;   // edge after which the DUT shows READDATA valid

    function automatic logic [127:0] block_of(input int a);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = model_mem[a*16 + k];
        return b;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        bit idle;
        cyc++;
        if (RESET) begin
            // Responder is idle at this edge once the done cycle has passed.
            idle    = cyc > done_at + 1;
            exp_err = bus.LOAD_EN && !(idle && !bus.READ);
            if (idle && bus.READ) begin
                exp_q.push_back(block_of(int'(bus.ADDRESS)));
                done_at = cyc + LAT;
            end else if (idle && bus.LOAD_EN) begin
                model_mem[bus.LOAD_ADDR] = bus.LOAD_DATA;
            end
        end
    end

    always @(negedge RESET) begin
        exp_q.delete();
        done_at = -10;
        exp_err = 1'b0;
        exp_rd  = '0;
        prev_bw = 1'b0;
    end

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        logic exp_bw;
        if (RESET) begin
            exp_bw = (cyc < done_at) ? 1'b1 : (cyc == done_at) ? 1'b0 : bus.READ;
            chk("busywait", bus.BUSYWAIT, exp_bw);
            chk("load_err", bus.LOAD_ERR, exp_err);
            if (prev_bw && !bus.BUSYWAIT) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    exp_rd = exp_q.pop_front();
                end
            end
            chk("readdata", bus.READDATA, exp_rd);
            prev_bw = bus.BUSYWAIT;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (cyc != done_at && n < 40) begin
            tick();
            n++;
        end
        if (cyc != done_at) chk("timeout_wait_done", 1, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_bw"},  bus.BUSYWAIT, 0);
        chk({tag, "_rd"},  bus.READDATA, 0);
        chk({tag, "_err"}, bus.LOAD_ERR, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.READ = 1'b0; bus.ADDRESS = '0;
        bus.LOAD_EN = 1'b0; bus.LOAD_ADDR = '0; bus.LOAD_DATA = '0;
        #1 RESET = 1'b0;
        #1 reset_checks("rst_init");
        tick(); tick();
        RESET = 1'b1;

        // Preload the full array; block 1 gets the 00..0F ramp.
        for (int i = 0; i < 1024; i++) begin
            bus.LOAD_EN   = 1'b1;
            bus.LOAD_ADDR = 10'(i);
            bus.LOAD_DATA = (i >= 16 && i < 32) ? 8'(i - 16) : 8'($urandom);
            tick();
        end
        bus.LOAD_EN = 1'b0;

        // Basic read of block 1.
        bus.READ = 1'b1; bus.ADDRESS = 6'd1;
        #1 chk("t2_bw_same_cycle", bus.BUSYWAIT, 1);
        tick(); bus.READ = 1'b0;
        wait_done();
        chk("t2_data", bus.READDATA, PAT1);
        chk("t2_bw_done", bus.BUSYWAIT, 0);
        tick();

        // Address change mid-transaction is ignored.
        bus.READ = 1'b1; bus.ADDRESS = 6'd1;
        tick(); bus.READ = 1'b0;
        tick(); bus.ADDRESS = 6'd2;
        wait_done();
        chk("t3_data", bus.READDATA, PAT1);
        tick();

        // Preload during BUSY is refused with a one-cycle error pulse.
        bus.READ = 1'b1; bus.ADDRESS = 6'd1;
        tick(); bus.READ = 1'b0;
        bus.LOAD_EN = 1'b1; bus.LOAD_ADDR = 10'h010; bus.LOAD_DATA = 8'hFF;
        tick(); bus.LOAD_EN = 1'b0;
        chk("t4_load_err", bus.LOAD_ERR, 1);
        tick();
        chk("t4_err_pulse", bus.LOAD_ERR, 0);
        wait_done(); tick();
        bus.READ = 1'b1; bus.ADDRESS = 6'd1;
        tick(); bus.READ = 1'b0;
        wait_done();
        chk("t4_byte0", {120'd0, bus.READDATA[7:0]}, 0);
        tick();

        // Reset while BUSY: immediate clear, memory contents survive.
        bus.READ = 1'b1; bus.ADDRESS = 6'd2;
        tick(); bus.READ = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        #1 reset_checks("t5_rst");
        tick();
        RESET = 1'b1;
        bus.READ = 1'b1; bus.ADDRESS = 6'd1;
        tick(); bus.READ = 1'b0;
        wait_done();
        chk("t5_data", bus.READDATA, PAT1);
        tick();

        // Back-to-back reads with READ held high.
        bus.READ = 1'b1; bus.ADDRESS = 6'd1;
        tick();
        wait_done();
        chk("t6_gap_low", bus.BUSYWAIT, 0);
        bus.ADDRESS = 6'd63;
        tick();
        chk("t6_gap_one_cycle", bus.BUSYWAIT, 1);
        tick(); bus.READ = 1'b0;
        wait_done();
        chk("t6_data", bus.READDATA, block_of(63));
        tick();

        // Random traffic: reads, preload attempts, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                bus.READ = 1'b0; bus.LOAD_EN = 1'b0;
                RESET = 1'b0;
                #1 reset_checks("rnd_rst");
                tick();
                RESET = 1'b1;
            end else begin
                bus.READ      = ($urandom_range(0, 3) == 0);
                bus.ADDRESS   = 6'($urandom);
                bus.LOAD_EN   = ($urandom_range(0, 2) == 0);
                bus.LOAD_ADDR = 10'($urandom);
                bus.LOAD_DATA = 8'($urandom);
                tick();
            end
        end

        bus.READ = 1'b0; bus.LOAD_EN = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("drain_queue_empty", 128'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
